// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: valid/ready FIFO on top of one single-port SRAM macro
// (one access per cycle, read data returned one cycle after the read).
// A 3-entry register staging buffer feeds deq_bits. Because of it, deq_ready
// has no combinational path to the SRAM port. Reads are issued only when the
// staging buffer has room for them, counting any read already in flight.
// While the SRAM and the read pipeline are empty, pushes bypass straight into
// the staging buffer.
module sram_fifo_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [DATA_W-1:0] enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [DATA_W-1:0] deq_bits,
  output logic [ADDR_W:0]   count,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int STG_N = 3;
  localparam logic [ADDR_W:0]   SRAM_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   sram_cnt;
  logic              inflight;
  logic [DATA_W-1:0] stg [STG_N];
  logic [1:0]        stg_cnt;

  logic              rd_issue;
  logic              bypass;
  logic              enq_fire;
  logic              enq_write;
  logic              enq_bypass;
  logic              deq_fire;
  logic              append;
  logic [DATA_W-1:0] append_data;
  logic [2:0]        stg_busy;
  logic [1:0]        tail;
  logic [1:0]        stg_cnt_nxt;
  logic [DATA_W-1:0] stg_nxt [STG_N];

  // Staging slots already claimed: held entries plus the read whose data
  // is still on its way back.
  assign stg_busy   = {1'b0, stg_cnt} + {2'b00, inflight};
  assign rd_issue   = (sram_cnt != '0) && (stg_busy < 3'd3);
  assign bypass     = (sram_cnt == '0) && !inflight && (stg_cnt < 2'd3);
  assign enq_ready  = !rd_issue && (bypass || (sram_cnt < SRAM_FULL));
  assign enq_fire   = enq_valid && enq_ready;
  assign enq_bypass = enq_fire && bypass;
  assign enq_write  = enq_fire && !bypass;

  assign deq_valid  = (stg_cnt != 2'd0);
  assign deq_bits   = stg[0];
  assign deq_fire   = deq_valid && deq_ready;

  // Capture and bypass never coincide, because bypass needs an empty read
  // pipeline.
  assign append      = inflight || enq_bypass;
  assign append_data = inflight ? sram_rdata : enq_bits;

  assign count = sram_cnt + (ADDR_W+1)'(inflight) + (ADDR_W+1)'(stg_cnt);

  // The read takes the port in preference to a write; enq_ready already
  // blocks pushes on read cycles.
  assign sram_en    = rd_issue || enq_write;
  assign sram_wmode = enq_write;
  assign sram_addr  = rd_issue ? rd_ptr : wr_ptr;
  assign sram_wdata = enq_bits;

  // Next staging contents: pop shifts valid entries toward the head, then
  // append lands at the new tail. A slot that is emptied keeps its data, so
  // deq_bits holds its last value when the buffer drains.
  always_comb begin
    for (int i = 0; i < STG_N; i++) stg_nxt[i] = stg[i];
    tail        = stg_cnt - {1'b0, deq_fire};
    stg_cnt_nxt = stg_cnt + {1'b0, append} - {1'b0, deq_fire};
    if (deq_fire) begin
      for (int i = 0; i < STG_N - 1; i++) begin
        if (i + 1 < int'(stg_cnt)) stg_nxt[i] = stg[i+1];
      end
    end
    for (int i = 0; i < STG_N; i++) begin
      if (append && (tail == 2'(i))) stg_nxt[i] = append_data;
    end
  end

  // Pointer, occupancy and staging registers. Reset drops any in-flight
  // read, and the resulting state makes old SRAM contents unreachable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sram_cnt <= '0;
      inflight <= 1'b0;
      stg_cnt  <= 2'd0;
      for (int i = 0; i < STG_N; i++) stg[i] <= '0;
    end else begin
      if (rd_issue) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        sram_cnt <= sram_cnt - CNT_ONE;
      end else if (enq_write) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        sram_cnt <= sram_cnt + CNT_ONE;
      end
      inflight <= rd_issue;
      stg_cnt  <= stg_cnt_nxt;
      for (int i = 0; i < STG_N; i++) stg[i] <= stg_nxt[i];
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural SRAM macro and a
// FIFO-order scoreboard.
module tb_sram_fifo_ctrl;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enq_valid = 1'b0;
  logic              enq_ready;
  logic [DATA_W-1:0] enq_bits = '0;
  logic              deq_valid;
  logic              deq_ready = 1'b0;
  logic [DATA_W-1:0] deq_bits;
  logic [ADDR_W:0]   count;
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata = '0;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q [$];

  int errors = 0;
  int checks = 0;
  int n_acc, n_pop, sram_acc, sram_wr, rd_cycles, viol, bubbles;

  always #5 clock = ~clock;

  // single-port macro model: one access per cycle, read data next cycle
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) mem[sram_addr] <= sram_wdata;
      else            sram_rdata     <= mem[sram_addr];
    end
  end

  sram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
    .count(count),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after a rising edge; this samples the handshakes
  // mid-cycle, then advances one clock.
  task automatic tick();
    #1;
    if (enq_valid && enq_ready) begin
      q.push_back(enq_bits);
      n_acc++;
    end
    if (deq_valid && deq_ready) begin
      n_pop++;
      chk("deq_model_nonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) chk("deq_order", deq_bits, q.pop_front());
    end
    if (sram_en) begin
      sram_acc++;
      if (sram_wmode) sram_wr++;
    end
    if (sram_en && !sram_wmode) begin
      rd_cycles++;
      if (enq_ready) viol++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_bits  = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    n_acc = 0; n_pop = 0; sram_acc = 0; sram_wr = 0;
    rd_cycles = 0; viol = 0; bubbles = 0;
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      enq_valid = 1'b1;
      enq_bits  = 64'(base + i);
      tick();
    end
    enq_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    for (int i = 0; i < 600 && (q.size() != 0 || deq_valid); i++) tick();
    deq_ready = 1'b0;
    #1;
    chk({tag, "_drained"}, 64'(q.size()), 64'd0);
    chk({tag, "_count0"}, 64'(count), 64'd0);
  endtask

  initial begin
    // 1: reset state and single bypass push
    do_reset();
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_deq_bits", deq_bits, 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_sram_en", 64'(sram_en), 64'd0);
    chk("rst_sram_wmode", 64'(sram_wmode), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    enq_valid = 1'b1;
    enq_bits  = 64'hA5;
    tick();
    enq_valid = 1'b0;
    #1;
    chk("t1_deq_valid", 64'(deq_valid), 64'd1);
    chk("t1_deq_bits", deq_bits, 64'hA5);
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_no_sram", 64'(sram_acc), 64'd0);
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    #1;
    chk("t1_empty", 64'(deq_valid), 64'd0);
    chk("t1_hold_bits", deq_bits, 64'hA5);
    chk("t1_pops", 64'(n_pop), 64'd1);

    // 2: fill to capacity with no pops, then drain in order
    do_reset();
    for (int i = 0; i < 201; i++) begin
      enq_valid = 1'b1;
      enq_bits  = 64'(n_acc);
      tick();
    end
    enq_valid = 1'b0;
    #1;
    chk("t2_accepted", 64'(n_acc), 64'd131);
    chk("t2_enq_ready", 64'(enq_ready), 64'd0);
    chk("t2_count", 64'(count), 64'd131);
    chk("t2_sram_writes", 64'(sram_wr), 64'd128);
    drain("t2");
    chk("t2_pops", 64'(n_pop), 64'd131);

    // 3: ten preloaded words stream out back-to-back
    do_reset();
    push_n(10, 16'h300);
    tick();
    tick();
    chk("t3_full_stage", 64'(count), 64'd10);
    deq_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!deq_valid) bubbles++;
      tick();
    end
    deq_ready = 1'b0;
    #1;
    chk("t3_bubbles", 64'(bubbles), 64'd0);
    chk("t3_pops", 64'(n_pop), 64'd10);
    chk("t3_empty", 64'(deq_valid), 64'd0);

    // 4: constant push pressure while reads stream
    do_reset();
    push_n(5, 16'h400);
    deq_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      enq_valid = 1'b1;
      enq_bits  = 64'(16'h500 + i);
      tick();
    end
    enq_valid = 1'b0;
    drain("t4");
    chk("t4_rd_seen", 64'(rd_cycles > 0), 64'd1);
    chk("t4_no_enq_on_rd", 64'(viol), 64'd0);

    // 5: reset lands while a read is in flight
    do_reset();
    push_n(5, 16'h600);
    deq_ready = 1'b1;
    for (int i = 0; i < 10 && rd_cycles == 0; i++) tick();
    chk("t5_rd_seen", 64'(rd_cycles), 64'd1);
    reset = 1'b1;
    #1;
    chk("t5_rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("t5_rst_count", 64'(count), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    for (int i = 0; i < 3; i++) tick();
    chk("t5_no_capture", 64'(deq_valid), 64'd0);
    chk("t5_count_after", 64'(count), 64'd0);
    deq_ready = 1'b0;

    // 6: random traffic, fill-biased then drain-biased, wrapping pointers
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if (c < 1000) begin
        enq_valid = ($urandom_range(0, 3) != 0);
        deq_ready = ($urandom_range(0, 3) == 0);
      end else begin
        enq_valid = ($urandom_range(0, 3) == 0);
        deq_ready = ($urandom_range(0, 3) != 0);
      end
      enq_bits = {$urandom, $urandom};
      tick();
      chk("t6_count", 64'(count), 64'(q.size()));
      chk("t6_count_max", 64'(count <= 131), 64'd1);
    end
    drain("t6");
    chk("t6_wrapped", 64'(sram_wr > 128), 64'd1);
    chk("t6_no_enq_on_rd", 64'(viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
